commu_rx: RTL and testbench
===========================

# commu_rx

Serial receive engine for the commu link, the far end of the commu transmitter that drives `tx`. It oversamples the asynchronous `rx` line on `clk_sys`, frames start/8-data/stop characters at the runtime bit rate `tbit_fre`, and delivers bytes. It also keeps the `rx_total` bit count that the board top compares against `tx_total` to light `led_ok`.

## Interface
- `CLK_KHZ`, 100000: `clk_sys` frequency in kHz.
- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `clk_sys`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: asynchronous serial line; idles high.
- `tbit_fre`, in, 16: bit rate in kbps. 0 disables reception.
- `clr`, in, 1: one-cycle synchronous clear of `rx_total` and `err_total`.
- `rx_data`, out, 8: last good byte.
- `rx_vld`, out, 1: one-cycle strobe; `rx_data` is new.
- `rx_total`, out, 32: data bits received in good frames.
- `err_total`, out, 16: framing errors; saturates at 0xFFFF.
- `now_recv`, out, 1: high while a frame is in progress, i.e. the state is not IDLE.

## Operation
- **Input path.** `rx` passes through a 2-flop synchronizer. A third flop holds the previous sample for falling-edge detection.
- **Bit timing.** A 32-bit phase accumulator `acc` runs in every state except IDLE.
  - Each cycle, if `acc + fre ≥ CLK_KHZ`, then `acc ← acc + fre − CLK_KHZ` and `tick` = 1.
  - Otherwise `acc ← acc + fre` and `tick` = 0.
  - `fre` is `tbit_fre` latched at start detection. Changes to `tbit_fre` mid-frame are ignored.
  - Supported range is 1 ≤ `tbit_fre` ≤ `CLK_KHZ`/4. Behaviour above that range is unspecified.
- **States:** IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE → START on a synchronized falling edge, when `tbit_fre` ≠ 0. On this transition `acc ← CLK_KHZ/2`, so every tick lands mid-bit.
  - START, on tick: if the sample = 0, go to DATA with bit index 0. If the sample = 1, the start was a glitch: return to IDLE with no outputs and no counters changed.
  - DATA, on tick: shift the sample into bit[index], LSB first. After the DATA_BITS-th bit, go to STOP.
  - STOP, on tick, sample = 1 (good frame):
    - load `rx_data`;
    - pulse `rx_vld`;
    - `rx_total += DATA_BITS` (wraps at 2^32);
    - go to IDLE.
  - STOP, on tick, sample = 0 (framing error): increment `err_total` (saturating), assert no `rx_vld`, go to WAIT_HI.
  - WAIT_HI → IDLE once the synchronized line is 1. A new start is only accepted after the line returns high.
- **Clear.** `clr` zeroes both counters. If `clr` coincides with a good-frame update, `clr` wins and `rx_total` = 0. A `clr` pulse does not disturb a frame in progress.
- **Reset.** `rst` asserted at any time, including mid-frame, immediately returns the block to its reset values below. The partial frame is discarded.
- **`tbit_fre` = 0.** The block stays in IDLE and ignores `rx`.

## Timing
- **Reset values:** state IDLE, `acc` = 0, `rx_data` = 0x00, `rx_vld` = 0, `rx_total` = 0, `err_total` = 0, `now_recv` = 0. Synchronizer flops reset to 1.
- **Start latency:** the falling edge on the `rx` pin is detected 3 cycles later (two synchronizer flops plus the edge compare).
- **Stop latency:** `rx_vld`, `rx_data` and `rx_total` update together in the cycle after the stop-bit tick and are registered. `rx_vld` is high for exactly one cycle.
- **Sample points:** ticks fall at 0.5, 1.5, …, 9.5 bit periods after detection, within ±1 cycle.
- **Back-to-back frames:** the block returns to IDLE 1 cycle after the stop tick, so a start edge arriving half a bit later is caught. A zero-gap stream is received without loss.
- **`now_recv`** is registered from the state. It rises the cycle after detection and falls the cycle after the return to IDLE.

## Structure
- **Shared package (`commu_pkg`):** the state enum, `DATA_BITS_DEF` = 8, and `CNT_W` = 32. The transmitter uses the same frame constants.
- **Sub-module `commu_nco`:** the phase-accumulator tick generator. Inputs are `clk_sys`, `rst`, `fre`, `load_half` and `run`; output is `tick`. Reused by the transmitter.
- **Top of this block:** FSM, shift register and counters, in `commu_rx`.

## Test plan
All scenarios use `CLK_KHZ` = 100000 and `tbit_fre` = 5000, i.e. 20 cycles per bit.
- **Single byte:** drive frame 0xA5 → one `rx_vld` pulse about 193 ±2 cycles after the start edge, `rx_data` = 0xA5, `rx_total` = 8, `err_total` = 0.
- **Start glitch:** hold `rx` low for 5 cycles, then high → no `rx_vld`, state back in IDLE, `now_recv` high at most about 14 cycles, counters unchanged.
- **Framing error:** frame 0x3C with stop = 0, hold line low 40 cycles, release, then a good frame 0x3C → `err_total` = 1, exactly one `rx_vld` with 0x3C, `rx_total` = 8.
- **Zero-gap stream:** send 0x00, 0xFF, 0x55, 0xAA with no gap → 4 pulses with data in order, `rx_total` = 32.
- **Reset and clear:**
  - assert `rst` for 1 cycle mid-DATA of frame 0x12 → all outputs at reset values; a following frame 0x34 is received correctly.
  - `clr` coinciding with a stop tick → `rx_total` = 0.
- **Rate change and disable:**
  - `tbit_fre` = 1000 (100 cycles/bit), frame 0x81 → received correctly.
  - `tbit_fre` = 0 with frames driven → no `rx_vld`, `now_recv` stays 0.

Source files
------------

// File: rtl/commu_pkg.sv
// commu_pkg: constants and types shared by the commu transmitter and receiver.
//   commu_state_e : receive framing states
//   DATA_BITS_DEF : default data bits per character
//   CNT_W         : width of the bit counter and the phase accumulator
package commu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } commu_state_e;

  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_W         = 32;

endpackage

// File: rtl/commu_nco.sv
// commu_nco: phase-accumulator bit-tick generator.
//   clk_sys   : system clock
//   rst       : synchronous active-high reset (accumulator to 0)
//   fre       : bit rate in kbps
//   load_half : preset the accumulator to half a bit period
//   run       : advance the accumulator this cycle
//   tick      : combinational strobe, high on the cycle the phase wraps
module commu_nco
  import commu_pkg::*;
#(
  parameter int CLK_KHZ = 100000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] fre,
  input  logic        load_half,
  input  logic        run,
  output logic        tick
);

  localparam logic [CNT_W:0]   CLK_FULL = (CNT_W+1)'(CLK_KHZ);
  localparam logic [CNT_W-1:0] CLK_HALF = CNT_W'(CLK_KHZ / 2);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   diff;

  // One extra bit on the sum so the compare can never overflow.
  assign sum  = {1'b0, acc_q} + {{(CNT_W+1-16){1'b0}}, fre};
  assign diff = sum - CLK_FULL;

  always_comb begin
    tick  = 1'b0;
    acc_d = acc_q;
    if (load_half) begin
      // Starting at half a period puts every later tick mid-bit.
      acc_d = CLK_HALF;
    end else if (run) begin
      if (sum >= CLK_FULL) begin
        tick  = 1'b1;
        acc_d = diff[CNT_W-1:0];
      end else begin
        acc_d = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/commu_rx.sv
// commu_rx: serial receive engine (start / DATA_BITS LSB-first / stop).
//   clk_sys   : system clock          rst       : sync active-high reset
//   rx        : async serial line     tbit_fre  : bit rate kbps (0 = off)
//   clr       : clear rx_total and err_total
//   rx_data   : last good byte        rx_vld    : one-cycle new-data strobe
//   rx_total  : data bits in good frames (wrapping)
//   err_total : framing errors (saturating)
//   now_recv  : registered "frame in progress"
module commu_rx
  import commu_pkg::*;
#(
  parameter int CLK_KHZ   = 100000,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [15:0]          tbit_fre,
  input  logic                 clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_vld,
  output logic [CNT_W-1:0]     rx_total,
  output logic [15:0]          err_total,
  output logic                 now_recv
);

  localparam int             IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  commu_state_e         state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [15:0]          fre_q, fre_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_vld_q, rx_vld_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic [15:0]          err_q, err_d;
  logic                 now_recv_q;
  logic                 fall, load_half, run, tick;

  assign fall = prev_q & ~sync2_q;
  assign run  = (state_q != ST_IDLE);

  commu_nco #(.CLK_KHZ(CLK_KHZ)) u_nco (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .fre       (fre_q),
    .load_half (load_half),
    .run       (run),
    .tick      (tick)
  );

  always_comb begin
    state_d   = state_q;
    fre_d     = fre_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    total_d   = total_q;
    err_d     = err_q;
    load_half = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall && (tbit_fre != 16'd0)) begin
          state_d   = ST_START;
          fre_d     = tbit_fre;   // rate frozen for the whole frame
          load_half = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          // A line already back high mid-start-bit was only a glitch.
          if (!sync2_q) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d[idx_q] = sync2_q;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sync2_q) begin
            rx_data_d = shift_q;
            rx_vld_d  = 1'b1;
            total_d   = total_q + CNT_W'(DATA_BITS);
            state_d   = ST_IDLE;
          end else begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            state_d = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        // Hold off until the line idles so a long break is not a new start.
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      total_d = '0;
      err_d   = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      fre_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      total_q    <= '0;
      err_q      <= '0;
      now_recv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      fre_q      <= fre_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      total_q    <= total_d;
      err_q      <= err_d;
      now_recv_q <= (state_q != ST_IDLE);
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_vld    = rx_vld_q;
  assign rx_total  = total_q;
  assign err_total = err_q;
  assign now_recv  = now_recv_q;

endmodule

// File: tb/tb_commu_rx.sv
module tb_commu_rx;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] tbit_fre;
  logic        clr;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [31:0] rx_total;
  logic [15:0] err_total;
  logic        now_recv;

  commu_rx #(.CLK_KHZ(100000), .DATA_BITS(8)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .rx        (rx),
    .tbit_fre  (tbit_fre),
    .clr       (clr),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .rx_total  (rx_total),
    .err_total (err_total),
    .now_recv  (now_recv)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  // Observed strobes and now_recv run length, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         nr_run = 0;
  int         nr_max = 0;

  always @(negedge clk_sys) begin
    if (rx_vld) begin
      got_q.push_back(rx_data);
      got_cyc.push_back(cyc);
    end
    if (now_recv) begin
      nr_run++;
      if (nr_run > nr_max) nr_max = nr_run;
    end else begin
      nr_run = 0;
    end
  end

  int          errors = 0;
  int          checks = 0;
  int          cpb    = 20;       // clock cycles per bit
  logic [31:0] exp_total = '0;
  logic [15:0] exp_err   = '0;

  // Expected pin-edge-to-strobe delay: 3 detect + half bit + 9 bits.
  function automatic int exp_lat();
    return 3 + cpb / 2 + 9 * cpb;
  endfunction

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, output int t0);
    t0 = cyc;
    hold(1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(d[i], cpb);
    hold(stop_v, cpb);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    nr_max = 0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk_sys);
    #1;
    clr = 1'b0;
    exp_total = '0;
    exp_err   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; clr = 1'b0; tbit_fre = 16'd5000;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_vld !== 1'b0)      begin errors++; $display("FAIL reset_rx_vld got=%b exp=0", rx_vld); end
    checks++; if (rx_total !== 32'd0)   begin errors++; $display("FAIL reset_rx_total got=%0d exp=0", rx_total); end
    checks++; if (err_total !== 16'd0)  begin errors++; $display("FAIL reset_err_total got=%0d exp=0", err_total); end
    checks++; if (now_recv !== 1'b0)    begin errors++; $display("FAIL reset_now_recv got=%b exp=0", now_recv); end
    rst = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_single();
    logic [7:0] d;
    int t0;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      clear_mon();
      send_frame(d, 1'b1, t0);
      hold(1'b1, 10);
      exp_total += 32'd8;
      $display("single byte %02h", d);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
      else begin
        checks++; if (got_q[0] !== d) begin errors++; $display("FAIL single_data got=%h exp=%h", got_q[0], d); end
        checks++; if ((got_cyc[0] - t0 < exp_lat() - 2) || (got_cyc[0] - t0 > exp_lat() + 2))
          begin errors++; $display("FAIL single_latency got=%0d exp=%0d", got_cyc[0] - t0, exp_lat()); end
      end
      checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL single_total got=%0d exp=%0d", rx_total, exp_total); end
      checks++; if (err_total !== exp_err)  begin errors++; $display("FAIL single_err got=%0d exp=%0d", err_total, exp_err); end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    hold(1'b0, 5);
    hold(1'b1, 60);
    $display("start glitch, now_recv run=%0d", nr_max);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_vld got=%0d exp=0", got_q.size()); end
    checks++; if (nr_max < 1 || nr_max > 14) begin errors++; $display("FAIL glitch_now_recv_len got=%0d exp=1..14", nr_max); end
    checks++; if (now_recv !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b exp=0", now_recv); end
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL glitch_total got=%0d exp=%0d", rx_total, exp_total); end
    checks++; if (err_total !== exp_err) begin errors++; $display("FAIL glitch_err got=%0d exp=%0d", err_total, exp_err); end
  endtask

  task automatic test_frame_err();
    int t0;
    pulse_clr();
    clear_mon();
    send_frame(8'h3C, 1'b0, t0);
    hold(1'b0, 40);
    hold(1'b1, 40);
    exp_err += 16'd1;
    $display("framing error frame, err_total=%0d", err_total);
    checks++; if (err_total !== exp_err) begin errors++; $display("FAIL ferr_count got=%0d exp=%0d", err_total, exp_err); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ferr_vld got=%0d exp=0", got_q.size()); end
    send_frame(8'h3C, 1'b1, t0);
    hold(1'b1, 10);
    exp_total += 32'd8;
    $display("good frame after error, pulses=%0d", got_q.size());
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ferr_good_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h3C) begin errors++; $display("FAIL ferr_good_data got=%h exp=3c", got_q[0]); end
    end
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL ferr_total got=%0d exp=%0d", rx_total, exp_total); end
    checks++; if (err_total !== exp_err) begin errors++; $display("FAIL ferr_err_after got=%0d exp=%0d", err_total, exp_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int         t0s[$];
    int         t0;
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    for (int k = 0; k < 4; k++) exp_q.push_back(8'($urandom_range(0, 255)));
    pulse_clr();
    clear_mon();
    foreach (exp_q[k]) begin
      send_frame(exp_q[k], 1'b1, t0);
      t0s.push_back(t0);
    end
    hold(1'b1, 10);
    exp_total = 32'(8 * exp_q.size());
    $display("zero-gap stream of %0d bytes, pulses=%0d", exp_q.size(), got_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[k]) begin
        checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        checks++; if ((got_cyc[k] - t0s[k] < exp_lat() - 2) || (got_cyc[k] - t0s[k] > exp_lat() + 2))
          begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", k, got_cyc[k] - t0s[k], exp_lat()); end
      end
    end
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL b2b_total got=%0d exp=%0d", rx_total, exp_total); end
  endtask

  task automatic test_rst_mid();
    int t0;
    clear_mon();
    // 0x12: start, then bits 0,1,0 -> reset lands mid-DATA
    hold(1'b0, cpb);
    hold(1'b0, cpb);
    hold(1'b1, cpb);
    hold(1'b0, cpb);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    exp_total = '0;
    exp_err   = '0;
    $display("reset mid-frame");
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_total !== 32'd0)  begin errors++; $display("FAIL rstmid_total got=%0d exp=0", rx_total); end
    checks++; if (err_total !== 16'd0) begin errors++; $display("FAIL rstmid_err got=%0d exp=0", err_total); end
    checks++; if (now_recv !== 1'b0)   begin errors++; $display("FAIL rstmid_now_recv got=%b exp=0", now_recv); end
    hold(1'b1, 40);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_vld got=%0d exp=0", got_q.size()); end
    send_frame(8'h34, 1'b1, t0);
    hold(1'b1, 10);
    exp_total += 32'd8;
    $display("frame after reset, pulses=%0d", got_q.size());
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h34) begin errors++; $display("FAIL rstmid_next_data got=%h exp=34", got_q[0]); end
    end
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL rstmid_next_total got=%0d exp=%0d", rx_total, exp_total); end
  endtask

  task automatic test_clr_stop();
    int t0;
    pulse_clr();
    clear_mon();
    send_frame(8'h5A, 1'b1, t0);
    hold(1'b1, 10);
    exp_total += 32'd8;
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL clr_pre_total got=%0d exp=%0d", rx_total, exp_total); end
    clear_mon();
    fork
      send_frame(8'hC3, 1'b1, t0);
      begin
        // clr sampled on the same edge as the stop-bit tick
        repeat (exp_lat() - 1) @(posedge clk_sys);
        #1;
        clr = 1'b1;
        @(posedge clk_sys);
        #1;
        clr = 1'b0;
      end
    join
    hold(1'b1, 10);
    exp_total = '0;
    exp_err   = '0;
    $display("clr on stop tick, rx_total=%0d", rx_total);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL clr_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hC3) begin errors++; $display("FAIL clr_data got=%h exp=c3", got_q[0]); end
    end
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL clr_total got=%0d exp=0", rx_total); end
  endtask

  task automatic test_rate();
    logic [7:0] d;
    int t0;
    tbit_fre = 16'd1000;
    cpb      = 100;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'h81 : 8'($urandom_range(0, 255));
      clear_mon();
      send_frame(d, 1'b1, t0);
      hold(1'b1, 20);
      exp_total += 32'd8;
      $display("rate 1000 byte %02h", d);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rate_count got=%0d exp=1", got_q.size()); end
      else begin
        checks++; if (got_q[0] !== d) begin errors++; $display("FAIL rate_data got=%h exp=%h", got_q[0], d); end
        checks++; if ((got_cyc[0] - t0 < exp_lat() - 2) || (got_cyc[0] - t0 > exp_lat() + 2))
          begin errors++; $display("FAIL rate_latency got=%0d exp=%0d", got_cyc[0] - t0, exp_lat()); end
      end
      checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL rate_total got=%0d exp=%0d", rx_total, exp_total); end
    end
    tbit_fre = 16'd5000;
    cpb      = 20;
  endtask

  task automatic test_disable();
    int t0;
    tbit_fre = 16'd0;
    clear_mon();
    send_frame(8'($urandom_range(0, 255)), 1'b1, t0);
    send_frame(8'h0F, 1'b0, t0);
    hold(1'b1, 40);
    $display("disabled, pulses=%0d now_recv run=%0d", got_q.size(), nr_max);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL dis_vld got=%0d exp=0", got_q.size()); end
    checks++; if (nr_max != 0) begin errors++; $display("FAIL dis_now_recv got=%0d exp=0", nr_max); end
    checks++; if (rx_total !== exp_total) begin errors++; $display("FAIL dis_total got=%0d exp=%0d", rx_total, exp_total); end
    checks++; if (err_total !== exp_err) begin errors++; $display("FAIL dis_err got=%0d exp=%0d", err_total, exp_err); end
    tbit_fre = 16'd5000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_rst_mid();
    test_clr_stop();
    test_rate();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
